// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single stalling data memory.
// One transaction at a time: grant, issue one strobe, wait for the stall handshake, then complete or abort.
module data_mem_arbiter #(
  parameter int unsigned TIMEOUT     = 15,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_mask,
  output logic        r0_done,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_mask,
  output logic        r1_done,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_ACK_WAIT = 3'd2,
    S_BUSY     = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        sel_s;
  logic        finish_s;
  logic        abort_s;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      mask_q   <= 4'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state, grant selection and output pulses.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    sel_s    = 1'b0;
    finish_s = 1'b0;
    abort_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The pointer only moves on contention, so a lone follow-up grant does not steal the next turn.
        if (r0_req && r1_req) begin
          sel_s  = (ROUND_ROBIN != 1'b0) ? ~last_q : 1'b0;
          last_d = sel_s;
        end else begin
          sel_s = r1_req;
        end
        if (r0_req || r1_req) begin
          gnt_d   = sel_s;
          we_d    = sel_s ? r1_we    : r0_we;
          addr_d  = sel_s ? r1_addr  : r0_addr;
          wdata_d = sel_s ? r1_wdata : r0_wdata;
          mask_d  = sel_s ? r1_mask  : r0_mask;
          rd_d    = ~we_d;
          wr_d    = we_d;
          cnt_d   = 8'd0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_clk_stall) begin
          state_d = S_BUSY;
        end else if (cnt_d == TIMEOUT_C) begin
          finish_s = 1'b1;
          abort_s  = 1'b1;
        end else begin
          state_d = S_ACK_WAIT;
        end
      end
      S_BUSY: begin
        if (!mem_clk_stall) begin
          finish_s = 1'b1;
          if (!we_q && gnt_q) begin
            rdata1_d = mem_read_data;
          end else if (!we_q) begin
            rdata0_d = mem_read_data;
          end else begin
            rdata0_d = rdata0_q;
          end
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish_s) begin
      state_d = S_DONE;
      done0_d = ~gnt_q;
      done1_d = gnt_q;
      err0_d  = abort_s & ~gnt_q;
      err1_d  = abort_s & gnt_q;
    end else begin
      done0_d = 1'b0;
      done1_d = 1'b0;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = rd_q;
  assign mem_memwrite   = wr_q;
  assign r0_done        = done0_q;
  assign r1_done        = done1_q;
  assign r0_err         = err0_q;
  assign r1_err         = err1_q;
  assign r0_rdata       = rdata0_q;
  assign r1_rdata       = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised and directed bench for data_mem_arbiter with a stalling memory model and a transaction-level scoreboard.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r0_addr = 32'd0, r0_wdata = 32'd0, r1_addr = 32'd0, r1_wdata = 32'd0;
  logic [3:0]  r0_mask = 4'd0, r1_mask = 4'd0;
  logic        r0_done, r0_err, r1_done, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memread, mem_memwrite, mem_clk_stall;
  logic [3:0]  mem_sign_mask;

  // second instance: fixed priority, memory that never answers
  logic        f_r0_req = 1'b0, f_r1_req = 1'b0;
  logic        f_r0_done, f_r0_err, f_r1_done, f_r1_err;
  logic [31:0] f_r0_rdata, f_r1_rdata, f_mem_addr, f_mem_wdata;
  logic        f_mem_rd, f_mem_wr;
  logic [3:0]  f_mem_mask;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  data_mem_arbiter #(.TIMEOUT(15), .ROUND_ROBIN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_mask(r0_mask),
    .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_mask(r1_mask),
    .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );

  data_mem_arbiter #(.TIMEOUT(3), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .r0_req(f_r0_req), .r0_we(1'b0), .r0_addr(32'h0000_0100), .r0_wdata(32'd0), .r0_mask(4'd0),
    .r0_done(f_r0_done), .r0_rdata(f_r0_rdata), .r0_err(f_r0_err),
    .r1_req(f_r1_req), .r1_we(1'b0), .r1_addr(32'h0000_0200), .r1_wdata(32'd0), .r1_mask(4'd0),
    .r1_done(f_r1_done), .r1_rdata(f_r1_rdata), .r1_err(f_r1_err),
    .mem_addr(f_mem_addr), .mem_write_data(f_mem_wdata), .mem_memread(f_mem_rd),
    .mem_memwrite(f_mem_wr), .mem_sign_mask(f_mem_mask),
    .mem_read_data(32'd0), .mem_clk_stall(1'b0)
  );

  function automatic logic [31:0] hash(input logic [3:0] i);
    return (32'h9E37_79B9 * {28'd0, i}) + 32'h1234_5678;
  endfunction

  // Memory model: an accepted strobe raises stall for stall_len cycles; stall_len = 0 never answers.
  int          stall_len = 1;
  logic [7:0]  stall_cnt = 8'd0;
  logic [31:0] rd_word = 32'd0;
  logic [31:0] mem_arr [0:15];
  logic [15:0] mem_wr = 16'd0;

  always @(posedge clk) begin
    if (stall_cnt != 8'd0) stall_cnt <= stall_cnt - 8'd1;
    if ((mem_memread || mem_memwrite) && stall_len > 0) begin
      stall_cnt <= 8'(stall_len);
      if (mem_memwrite) begin
        mem_arr[mem_addr[5:2]] <= mem_write_data;
        mem_wr[mem_addr[5:2]]  <= 1'b1;
      end else begin
        rd_word <= mem_wr[mem_addr[5:2]] ? mem_arr[mem_addr[5:2]] : hash(mem_addr[5:2]);
      end
    end
  end

  assign mem_clk_stall = (stall_cnt != 8'd0);
  assign mem_read_data = rd_word;

  // scoreboard
  logic [31:0] ref_mem [0:15];
  logic [15:0] ref_wr = 16'd0;
  logic [31:0] ref_rdata [0:1];
  int          ref_last = 1;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_wr[a[5:2]] ? ref_mem[a[5:2]] : hash(a[5:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_port(input int p, input logic req, input logic we,
                            input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    if (p == 0) begin
      r0_we = we; r0_addr = a; r0_wdata = wd; r0_mask = m; r0_req = req;
    end else begin
      r1_we = we; r1_addr = a; r1_wdata = wd; r1_mask = m; r1_req = req;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    chk({tag, "_mem_mask"}, {28'd0, mem_sign_mask}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, mem_memread, mem_memwrite}, 32'd0);
    chk({tag, "_done_err"}, {28'd0, r0_done, r1_done, r0_err, r1_err}, 32'd0);
    chk({tag, "_r0_rdata"}, r0_rdata, 32'd0);
    chk({tag, "_r1_rdata"}, r1_rdata, 32'd0);
  endtask

  // One transaction on one port, checked end to end against the scoreboard.
  task automatic run_single(input int p, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] m, input int sl,
                            output int first_k);
    int issue_cyc, n_rd, n_wr, exp_lat;
    bit got;
    logic cur_done, cur_err, oth_done;
    logic [31:0] cur_rdata, oth_rdata;
    stall_len = sl;
    issue_cyc = -1; n_rd = 0; n_wr = 0; got = 1'b0; first_k = -1;
    drive_port(p, 1'b1, we, a, wd, m);
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (mem_memread || mem_memwrite) begin
        chk("strobe_exclusive", {31'd0, mem_memread & mem_memwrite}, 32'd0);
        chk("issue_addr", mem_addr, a);
        chk("issue_mask", {28'd0, mem_sign_mask}, {28'd0, m});
        if (we) chk("issue_wdata", mem_write_data, wd);
        n_rd += int'(mem_memread);
        n_wr += int'(mem_memwrite);
        issue_cyc = cyc;
        if (first_k < 0) first_k = k;
      end
      cur_done  = (p == 0) ? r0_done  : r1_done;
      cur_err   = (p == 0) ? r0_err   : r1_err;
      oth_done  = (p == 0) ? r1_done  : r0_done;
      cur_rdata = (p == 0) ? r0_rdata : r1_rdata;
      oth_rdata = (p == 0) ? r1_rdata : r0_rdata;
      if (oth_done) chk("other_port_done", 32'd1, 32'd0);
      if (cur_done) begin
        got = 1'b1;
        exp_lat = (sl == 0) ? 16 : sl + 2;
        chk("latency", 32'(cyc - issue_cyc), 32'(exp_lat));
        chk("err", {31'd0, cur_err}, {31'd0, sl == 0});
        chk("read_pulses", 32'(n_rd), {31'd0, ~we});
        chk("write_pulses", 32'(n_wr), {31'd0, we});
        chk("addr_hold", mem_addr, a);
        if (!we && sl > 0) ref_rdata[p] = ref_read(a);
        if (we && sl > 0) begin
          ref_mem[a[5:2]] = wd;
          ref_wr[a[5:2]]  = 1'b1;
        end
        chk("rdata", cur_rdata, ref_rdata[p]);
        chk("other_rdata", oth_rdata, ref_rdata[1 - p]);
        drive_port(p, 1'b0, we, a, wd, m);
      end
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      drive_port(p, 1'b0, we, a, wd, m);
    end
  endtask

  // Both ports read at once; the scoreboard predicts who goes first.
  task automatic run_pair(input logic [31:0] a0, input int sl);
    int exp_first, n;
    int order [0:1];
    logic [31:0] a1;
    a1 = a0 ^ 32'h0000_0004;
    exp_first = (ref_last == 1) ? 0 : 1;
    stall_len = sl;
    n = 0; order[0] = -1; order[1] = -1;
    drive_port(0, 1'b1, 1'b0, a0, 32'd0, 4'd0);
    drive_port(1, 1'b1, 1'b0, a1, 32'd0, 4'd0);
    for (int k = 0; k < 80 && n < 2; k++) begin
      @(negedge clk);
      if (r0_done && r1_done) chk("pair_both_done", 32'd1, 32'd0);
      if (r0_done) begin
        order[n] = 0; n++;
        ref_rdata[0] = ref_read(a0);
        chk("pair_r0_rdata", r0_rdata, ref_rdata[0]);
        chk("pair_r0_err", {31'd0, r0_err}, 32'd0);
        r0_req = 1'b0;
      end else if (r1_done) begin
        order[n] = 1; n++;
        ref_rdata[1] = ref_read(a1);
        chk("pair_r1_rdata", r1_rdata, ref_rdata[1]);
        chk("pair_r1_err", {31'd0, r1_err}, 32'd0);
        r1_req = 1'b0;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    chk("pair_first", 32'(order[0]), 32'(exp_first));
    chk("pair_second", 32'(order[1]), 32'(1 - exp_first));
    ref_last = exp_first;
  endtask

  initial begin
    int fk, n0, n1, n0e, seen;
    logic [31:0] tmp, tmp2;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'd0;
    end
    ref_rdata[0] = 32'd0;
    ref_rdata[1] = 32'd0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // seed 0x10 then read it back from port 0
    run_single(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 2, fk);
    run_single(0, 1'b0, 32'h0000_0010, 32'd0, 4'b0010, 2, fk);
    chk("single_read_value", r0_rdata, 32'hDEAD_BEEF);

    run_single(1, 1'b1, 32'h0000_2000, 32'h0000_00AA, 4'b0000, 3, fk);
    chk("write_keeps_rdata", r1_rdata, ref_rdata[1]);

    run_single(0, 1'b0, 32'h0000_0030, 32'd0, 4'b0001, 0, fk);
    run_single(0, 1'b0, 32'h0000_0010, 32'd0, 4'b0000, 1, fk);

    run_pair(32'h0000_0040, 2);
    run_pair(32'h0000_0080, 1);

    for (int i = 0; i < 16; i++) begin
      tmp  = $urandom();
      tmp2 = $urandom();
      run_single(int'($urandom_range(0, 1)), tmp2[0], tmp & 32'hFFFF_FFFC, tmp2, tmp2[7:4],
                 int'($urandom_range(0, 4)), fk);
    end
    for (int i = 0; i < 6; i++) begin
      tmp = $urandom();
      run_pair(tmp & 32'hFFFF_FFF8, int'($urandom_range(1, 3)));
    end

    // reset while the memory is still stalling
    stall_len = 6;
    drive_port(0, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 4'd0);
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (mem_memread) seen = 1;
    end
    chk("rst_test_issue", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_test_busy_no_done", {31'd0, r0_done}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    r0_req = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (r0_done || r1_done || r0_err || r1_err) seen = 1;
    end
    chk("midreset_no_done", 32'(seen), 32'd0);
    ref_rdata[0] = 32'd0;
    ref_rdata[1] = 32'd0;
    ref_last = 1;
    rst_n = 1'b1;
    run_single(0, 1'b0, 32'h0000_0024, 32'd0, 4'd0, 2, fk);
    chk("first_accept_after_reset", 32'(fk), 32'd0);
    run_pair(32'h0000_0008, 1);

    // fixed priority: port 1 starved while port 0 keeps requesting
    f_r0_req = 1'b1;
    f_r1_req = 1'b1;
    n0 = 0; n1 = 0; n0e = 0;
    repeat (60) begin
      @(negedge clk);
      if (f_r0_done) n0++;
      if (f_r0_done && f_r0_err) n0e++;
      if (f_r1_done) n1++;
    end
    chk("fp_r1_starved", 32'(n1), 32'd0);
    chk("fp_r0_served", 32'(n0 >= 8), 32'd1);
    chk("fp_r0_err_with_done", 32'(n0e), 32'(n0));
    f_r0_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (f_r1_done) seen = 1;
    end
    f_r1_req = 1'b0;
    chk("fp_r1_after_release", 32'(seen), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
